// File: rtl/fifo_drain_serializer.sv
// Read-side consumer of the clock-crossing FIFO: pops one word, then streams it
// out MSB-first as OUT_W-bit beats over valid/ready, counting completed words.
module fifo_drain_serializer #(
  parameter int DATA_W = 140,
  parameter int OUT_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk_out,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] data_from_fifo,
  output logic              fifo_r_enable,
  output logic [OUT_W-1:0]  data_out,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic              data_out_last,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int BEATS  = (DATA_W + OUT_W - 1) / OUT_W;
  localparam int PAD    = BEATS * OUT_W - DATA_W;
  localparam int PAD_W  = BEATS * OUT_W;
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, LOAD, SEND} state_t;

  state_t              state;
  logic [DATA_W-1:0]   word_q;
  logic [BCNT_W-1:0]   beat_cnt;
  logic [BCNT_W-1:0]   beat_nxt;

  assign beat_nxt = beat_cnt + BCNT_W'(1);

  // Beat idx of the word left-justified in a BEATS*OUT_W field, beat 0 on top.
  function automatic logic [OUT_W-1:0] beat_of(input logic [DATA_W-1:0] word,
                                               input logic [BCNT_W-1:0] idx);
    logic [PAD_W-1:0] padded;
    padded = PAD_W'(word) << PAD;
    return padded[(BEATS - 1 - int'(idx)) * OUT_W +: OUT_W];
  endfunction

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      fifo_r_enable  <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      data_out_last  <= 1'b0;
      word_cnt       <= '0;
      beat_cnt       <= '0;
      word_q         <= '0;
    end else begin
      fifo_r_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_r_enable <= 1'b1;
            state         <= READ;
          end
        end
        READ: state <= LOAD;
        // FIFO read data is valid now; present beat 0 straight from it
        LOAD: begin
          word_q         <= data_from_fifo;
          beat_cnt       <= '0;
          data_out       <= beat_of(data_from_fifo, '0);
          data_out_valid <= 1'b1;
          data_out_last  <= (BEATS == 1);
          state          <= SEND;
        end
        SEND: begin
          if (data_out_ready) begin
            if (beat_cnt == LAST_BEAT) begin
              word_cnt       <= word_cnt + CNT_W'(1);
              beat_cnt       <= '0;
              data_out_valid <= 1'b0;
              data_out_last  <= 1'b0;
              // Chain straight into the next read to keep 11-cycle throughput
              if (!fifo_empty) begin
                fifo_r_enable <= 1'b1;
                state         <= READ;
              end else begin
                state <= IDLE;
              end
            end else begin
              beat_cnt      <= beat_nxt;
              data_out      <= beat_of(word_q, beat_nxt);
              data_out_last <= (beat_nxt == LAST_BEAT);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
